// File: rtl/fetch_unit_if.sv
// Fetch-stage bus bundle: instruction-memory request/response, decode handoff
// and execute redirect.
//   master : the fetch unit (drives requests, decode-side insn/insnPC/insnValid)
//   slave  : environment (memory, decode, execute)
interface fetch_unit_if;
    logic        imemReqValid;
    logic [31:0] imemReqAddr;
    logic        imemReqReady;
    logic        imemRespValid;
    logic [31:0] imemRespInsn;
    logic        insnValid;
    logic [31:0] insn;
    logic [31:0] insnPC;
    logic        insnReady;
    logic        redirect;
    logic [31:0] redirectPC;

    modport master (
        output imemReqValid, imemReqAddr, insnValid, insn, insnPC,
        input  imemReqReady, imemRespValid, imemRespInsn, insnReady, redirect, redirectPC
    );

    modport slave (
        input  imemReqValid, imemReqAddr, insnValid, insn, insnPC,
        output imemReqReady, imemRespValid, imemRespInsn, insnReady, redirect, redirectPC
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage. Owns the PC, issues in-order requests to instruction
// memory under a credit limit, buffers returned words with their PCs in a small
// FIFO and hands {insn, insnPC} to decode over valid/ready. A redirect from
// execute flushes the buffer, restarts at the target and discards every
// response still owed for the old path.
// Ports:
//   clk  - clock, all state on rising edge
//   rst  - asynchronous active-high reset
//   bus  - fetch_unit_if.master (imem request/response, decode handoff, redirect)
module fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst,
    fetch_unit_if.master bus
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC;

    typedef logic [AW-1:0] ptr_t;
    typedef logic [CW-1:0] cnt_t;
    typedef logic [CW:0]   sum_t;

    localparam cnt_t DEPTH_C = cnt_t'(FIFO_DEPTH);

    logic [31:0] pc_q;
    cnt_t        outstanding_q;
    cnt_t        drop_q;
    cnt_t        count_q;
    ptr_t        fifo_head_q, fifo_tail_q;
    ptr_t        pcq_head_q, pcq_tail_q;

    logic [31:0] fifo_insn_q [FIFO_DEPTH];
    logic [31:0] fifo_pc_q   [FIFO_DEPTH];
    // PCs of issued-but-unanswered requests, in issue order.
    logic [31:0] pcq_q       [FIFO_DEPTH];

    sum_t        inflight;
    logic        req_valid;
    logic        req_fire;
    logic        resp;
    logic        push;
    logic        pop;
    logic        out_valid;

    always_comb begin
        inflight  = sum_t'(outstanding_q) + sum_t'(count_q);
        // Credit covers both buffered words and words still in flight, so a
        // response always finds a free FIFO slot.
        req_valid = !rst && !bus.redirect && (drop_q == '0) && (inflight < sum_t'(DEPTH_C));
        req_fire  = req_valid && bus.imemReqReady;
        resp      = bus.imemRespValid;
        // Responses arriving during a redirect, or while old-path words are owed,
        // are discarded.
        push      = resp && !bus.redirect && (drop_q == '0);
        out_valid = (count_q != '0) && !bus.redirect;
        pop       = out_valid && bus.insnReady;

        bus.imemReqValid = req_valid;
        bus.imemReqAddr  = pc_q;
        bus.insnValid    = out_valid;
        bus.insn         = out_valid ? fifo_insn_q[fifo_head_q] : '0;
        bus.insnPC       = out_valid ? fifo_pc_q[fifo_head_q]   : '0;
    end

    // Storage needs no reset: validity is tracked by the pointers and counters.
    always_ff @(posedge clk) begin
        if (req_fire) begin
            pcq_q[pcq_tail_q] <= pc_q;
        end
        if (push) begin
            fifo_insn_q[fifo_tail_q] <= bus.imemRespInsn;
            fifo_pc_q[fifo_tail_q]   <= pcq_q[pcq_head_q];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q          <= RESET_PC & ALIGN_MASK;
            outstanding_q <= '0;
            drop_q        <= '0;
            count_q       <= '0;
            fifo_head_q   <= '0;
            fifo_tail_q   <= '0;
            pcq_head_q    <= '0;
            pcq_tail_q    <= '0;
        end else begin
            // req_fire is already suppressed during a redirect.
            outstanding_q <= outstanding_q + cnt_t'(req_fire) - cnt_t'(resp);
            if (req_fire) begin
                pcq_tail_q <= pcq_tail_q + ptr_t'(1);
            end
            if (resp) begin
                pcq_head_q <= pcq_head_q + ptr_t'(1);
            end

            if (bus.redirect) begin
                pc_q        <= bus.redirectPC & ALIGN_MASK;
                count_q     <= '0;
                fifo_head_q <= '0;
                fifo_tail_q <= '0;
                // Every word still owed after this cycle belongs to the old path.
                // No request fires while dropping, so this is simply the next
                // outstanding count, whether or not a drop was already under way.
                drop_q      <= outstanding_q - cnt_t'(resp);
            end else begin
                if (req_fire) begin
                    pc_q <= pc_q + 32'd4;
                end
                if (resp && (drop_q != '0)) begin
                    drop_q <= drop_q - cnt_t'(1);
                end
                if (push) begin
                    fifo_tail_q <= fifo_tail_q + ptr_t'(1);
                end
                if (pop) begin
                    fifo_head_q <= fifo_head_q + ptr_t'(1);
                end
                count_q <= count_q + cnt_t'(push) - cnt_t'(pop);
            end
        end
    end

    outstanding_le_depth_a: assert property (
        @(posedge clk) disable iff (rst) outstanding_q <= DEPTH_C
    );
endmodule
